// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide engine producing a MIPS-style HI/LO result.
// Shift-add multiply and restoring divide, one bit per clock, start/busy/done handshake.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  logic               w_acc_mul;
  logic               w_acc_div;
  logic               w_div0;
  logic               w_last;
  logic [WIDTH:0]     w_upper;
  logic [2*WIDTH:0]   w_acc_nxt;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quot_nxt;

  assign w_acc_mul = (r_state == S_IDLE) && start && (funct == FUNCT_MUL);
  assign w_acc_div = (r_state == S_IDLE) && start && (funct == FUNCT_DIV) && (b != '0);
  assign w_div0    = (r_state == S_IDLE) && start && (funct == FUNCT_DIV) && (b == '0);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // Multiply: add multiplicand into upper half when multiplier LSB is set, then shift right.
  assign w_upper   = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {1'b0, w_upper, r_acc[WIDTH-1:1]};

  // Divide: shift {rem,quot} left, keep the trial difference only if it did not borrow.
  // The difference is taken modulo 2^WIDTH; it is only used when it fits.
  assign w_shift    = {r_rem, r_quot[WIDTH-1]};
  assign w_borrow   = (w_shift < {1'b0, r_dvsr});
  assign w_diff     = w_shift[WIDTH-1:0] - r_dvsr;
  assign w_rem_nxt  = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
  assign w_quot_nxt = {r_quot[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc_mul)      w_next = S_MUL;
        else if (w_acc_div) w_next = S_DIV;
        else if (w_div0)    w_next = S_DONE;
      end
      S_MUL: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_dvsr  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else if (w_acc_mul) begin
      r_acc   <= {{(WIDTH+1){1'b0}}, b};
      r_mcand <= a;
      r_cnt   <= '0;
    end else if (w_acc_div) begin
      r_rem   <= '0;
      r_quot  <= a;
      r_dvsr  <= b;
      r_cnt   <= '0;
    end else if (w_div0) begin
      r_hi  <= a;
      r_lo  <= '1;
      r_dbz <= 1'b1;
    end else if (r_state == S_MUL) begin
      // Final iteration's result goes straight to hi/lo on the edge that enters DONE.
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_hi  <= w_acc_nxt[2*WIDTH-1:WIDTH];
        r_lo  <= w_acc_nxt[WIDTH-1:0];
        r_dbz <= 1'b0;
      end
    end else if (r_state == S_DIV) begin
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        r_hi  <= w_rem_nxt;
        r_lo  <= w_quot_nxt;
        r_dbz <= 1'b0;
      end
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO results,
// a monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  localparam int unsigned W = 32;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_DIV = 6'b011010;
  localparam logic [5:0] F_BAD = 6'b100000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = q.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        end
      end
    end
  end

  // Issue one operation from IDLE and check its latency and busy duration.
  task automatic do_op(input logic [5:0] f, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                       input int elat, input int ebusy);
    int lat;
    int nb;
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct = f; a = ia; b = ib;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ia; b = ~ib;
    lat = 1;
    nb  = 0;
    while (!done && lat < 100) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("busy_cycles", 64'(nb), 64'(ebusy));
    @(posedge clk);
  endtask

  initial begin
    int nb;
    int nd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op(F_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 32);
    do_op(F_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 32);
    do_op(F_MUL, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, 33, 32);
    do_op(F_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32);
    do_op(F_DIV, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 33, 32);
    do_op(F_DIV, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA, 1'b0, 33, 32);
    do_op(F_DIV, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 33, 32);
    do_op(F_DIV, 32'd123, 32'd0, 32'd123, 32'hFFFFFFFF, 1'b1, 1, 0);
    chk("dbz_held_idle", 64'(div_by_zero), 64'(1));
    do_op(F_MUL, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 33, 32);

    // Extra start pulses mid-mul and during DONE must be ignored.
    fork
      do_op(F_MUL, 32'd1000, 32'd3, 32'd0, 32'd3000, 1'b0, 33, 32);
      begin
        repeat (10) @(negedge clk);
        start = 1'b1; funct = F_DIV; a = 32'd77; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        @(posedge done);
        @(negedge clk);
        start = 1'b1; funct = F_MUL; a = 32'd11; b = 32'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    nb = 0; nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy) nb++;
      if (done) nd++;
    end
    chk("no_requeue_busy", 64'(nb), 64'(0));
    chk("no_requeue_done", 64'(nd), 64'(0));

    // Unsupported funct in IDLE: no activity at all.
    @(negedge clk);
    start = 1'b1; funct = F_BAD; a = 32'd4; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    nb = 0; nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy) nb++;
      if (done) nd++;
    end
    chk("bad_funct_busy", 64'(nb), 64'(0));
    chk("bad_funct_done", 64'(nd), 64'(0));
    chk("bad_funct_lo_held", 64'(lo), 64'(3000));

    // Asynchronous reset during iteration 10 of a divide.
    @(negedge clk);
    start = 1'b1; funct = F_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op(F_MUL, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 32);

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
